// File: rtl/second_largest_ctrl.sv
// second_largest_ctrl: round-robin session controller that time-shares one second_largest tracker.
// Optional stall timeout is compiled in with `define SLC_STALL_TIMEOUT_EN.
module second_largest_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 4,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic [NUM_REQ-1:0]              gnt,
  input  logic [NUM_REQ-1:0]              s_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_data,
  output logic [NUM_REQ-1:0]              s_ready,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [DATA_WIDTH-1:0]           resp_data,
  output logic [$clog2(NUM_REQ)-1:0]      resp_id,
  output logic                            resp_err,
  output logic                            trk_resetn,
  output logic [DATA_WIDTH-1:0]           trk_din,
  input  logic [DATA_WIDTH-1:0]           trk_dout
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, RESP} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        grant_idx;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        win_idx;
  logic                 win_found;
  logic [IW:0]          cand;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 accept;
  logic                 handshake;
  logic                 timeout;
  logic                 err_q;

  // Search starts at ptr and wraps, so the last granted requester has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!win_found && req[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  assign accept    = (state == STREAM) && s_valid[grant_idx];
  assign handshake = (state == RESP) && resp_ready;

`ifdef SLC_STALL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] stall_cnt;

  assign timeout = (state == STREAM) && !accept && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state != STREAM || accept) stall_cnt <= '0;
      else                           stall_cnt <= stall_cnt + 1'b1;
      if (state == CLEAR)  err_q <= 1'b0;
      else if (timeout)    err_q <= 1'b1;
    end
  end
`else
  // Without the stall counter the timeout path can never fire.
  assign timeout = (TIMEOUT_CYCLES < 0);
  assign err_q   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = CLEAR;
      CLEAR:   state_nxt = (remaining == '0) ? RESP : STREAM;
      STREAM:  if ((accept && remaining == LEN_WIDTH'(1)) || timeout) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      grant_idx <= '0;
      ptr       <= '0;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && win_found) begin
        grant_idx <= win_idx;
        remaining <= req_len[win_idx*LEN_WIDTH +: LEN_WIDTH];
      end
      if (accept) remaining <= remaining - 1'b1;
      if (handshake) ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // trk_din idles at 0 so the tracker holds, which keeps resp_data stable in RESP.
  always_comb begin
    gnt        = '0;
    s_ready    = '0;
    trk_din    = '0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_id    = '0;
    resp_err   = 1'b0;
    if (state != IDLE) gnt[grant_idx] = 1'b1;
    if (state == STREAM) s_ready[grant_idx] = 1'b1;
    if (accept) trk_din = s_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    if (state == RESP) begin
      resp_valid = 1'b1;
      resp_data  = trk_dout;
      resp_id    = grant_idx;
      resp_err   = err_q;
    end
  end

  assign trk_resetn = resetn & (state != CLEAR);

endmodule

// File: tb/tb_second_largest_ctrl.sv
// tb_second_largest_ctrl: directed checks of second_largest_ctrl against a behavioral tracker stub.
// Build with `define SLC_STALL_TIMEOUT_EN to exercise the stall timeout.
module tb_second_largest_ctrl;

  logic         clk = 1'b0;
  logic         resetn;
  logic [3:0]   req;
  logic [31:0]  req_len;
  logic [3:0]   gnt;
  logic [3:0]   s_valid;
  logic [127:0] s_data;
  logic [3:0]   s_ready;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_data;
  logic [1:0]   resp_id;
  logic         resp_err;
  logic         trk_resetn;
  logic [31:0]  trk_din;
  logic [31:0]  trk_dout;

  logic [31:0]  trk_max;
  logic [31:0]  trk_sec;

  int checks = 0;
  int fails  = 0;

  second_largest_ctrl #(
    .DATA_WIDTH(32), .NUM_REQ(4), .LEN_WIDTH(8), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_len(req_len), .gnt(gnt),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .resp_err(resp_err),
    .trk_resetn(trk_resetn), .trk_din(trk_din), .trk_dout(trk_dout)
  );

  always #5 clk = ~clk;

  // Tracker stub: only a strictly greater value than max or second (and not equal to max) updates.
  always @(posedge clk) begin
    if (!trk_resetn) begin
      trk_max <= '0;
      trk_sec <= '0;
    end else if (trk_din > trk_max) begin
      trk_sec <= trk_max;
      trk_max <= trk_din;
    end else if (trk_din > trk_sec && trk_din != trk_max) begin
      trk_sec <= trk_din;
    end
  end
  assign trk_dout = trk_sec;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic finish_resp;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  // Runs one session from IDLE; returns response fields and cycles from req sample to resp_valid.
  task automatic do_session(input int idx, input int len, input logic [31:0] vals [8],
                            output logic [31:0] rdata, output int rid, output int lat,
                            output logic ok);
    int k;
    k     = 0;
    lat   = 0;
    ok    = 1'b0;
    rdata = '0;
    rid   = 0;
    req[idx] = 1'b1;
    req_len[idx*8 +: 8] = 8'(len);
    for (int c = 0; c < 60; c++) begin
      tick();
      lat++;
      req[idx]     = 1'b0;
      s_valid[idx] = 1'b0;
      if (resp_valid) begin
        ok    = 1'b1;
        rdata = resp_data;
        rid   = int'(resp_id);
        break;
      end
      if (s_ready[idx] && k < len) begin
        s_valid[idx] = 1'b1;
        s_data[idx*32 +: 32] = vals[k];
        k++;
      end
    end
    s_valid[idx] = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0 || s_ready !== 4'b0) begin
      fails++;
      $display("[TB] FAIL reset_gnt_ready: gnt=%b s_ready=%b expected 0000 0000", gnt, s_ready);
    end
    checks++;
    if (resp_valid !== 1'b0 || resp_data !== 32'd0 || resp_id !== 2'd0 || resp_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_resp: valid=%b data=%0d id=%0d err=%b expected all 0",
               resp_valid, resp_data, resp_id, resp_err);
    end
    checks++;
    if (trk_din !== 32'd0 || trk_resetn !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_trk: din=%0d resetn=%b expected 0 0", trk_din, trk_resetn);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (trk_resetn !== 1'b1) begin
      fails++;
      $display("[TB] FAIL idle_trk_resetn: got %b expected 1", trk_resetn);
    end
  endtask

  task automatic test_basic;
    logic [31:0] v [8];
    logic [31:0] rd;
    int rid, lat;
    logic ok;
    v = '{32'd3, 32'd9, 32'd4, 32'd7, 32'd1, 32'd0, 32'd0, 32'd0};
    do_session(0, 5, v, rd, rid, lat, ok);
    checks++;
    if (!ok || rd !== 32'd7 || rid != 0) begin
      fails++;
      $display("[TB] FAIL basic_result: ok=%b data=%0d id=%0d expected 1 7 0", ok, rd, rid);
    end
    checks++;
    if (lat != 7) begin
      fails++;
      $display("[TB] FAIL basic_latency: got %0d expected 7", lat);
    end
    checks++;
    if (gnt !== 4'b0001 || resp_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_gnt_err: gnt=%b err=%b expected 0001 0", gnt, resp_err);
    end
    finish_resp();
    checks++;
    if (gnt !== 4'b0000 || resp_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_release: gnt=%b valid=%b expected 0000 0", gnt, resp_valid);
    end
  endtask

  task automatic test_round_robin;
    int exp_id [4];
    int multi;
    logic ok;
    exp_id = '{1, 2, 1, 2};
    multi  = 0;
    req_len[8 +: 8]  = 8'd1;
    req_len[16 +: 8] = 8'd1;
    s_data[32 +: 32] = 32'd11;
    s_data[64 +: 32] = 32'd22;
    s_valid = 4'b0110;
    req     = 4'b0110;
    for (int s = 0; s < 4; s++) begin
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
        tick();
        if ((gnt & (gnt - 4'd1)) != 4'd0) multi++;
        if (resp_valid) begin
          ok = 1'b1;
          break;
        end
      end
      checks++;
      if (!ok || int'(resp_id) != exp_id[s] || gnt !== (4'b0001 << exp_id[s])) begin
        fails++;
        $display("[TB] FAIL rr_order[%0d]: ok=%b id=%0d gnt=%b expected id %0d", s, ok, resp_id,
                 gnt, exp_id[s]);
      end
      finish_resp();
    end
    req     = 4'b0000;
    s_valid = 4'b0000;
    checks++;
    if (multi != 0) begin
      fails++;
      $display("[TB] FAIL rr_onehot: %0d cycles with multiple gnt bits, expected 0", multi);
    end
  endtask

  task automatic test_equal_values;
    logic [31:0] v [8];
    logic [31:0] rd;
    int rid, lat;
    logic ok;
    v = '{32'd5, 32'd5, 32'd5, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0};
    do_session(0, 4, v, rd, rid, lat, ok);
    checks++;
    if (!ok || rd !== 32'd2) begin
      fails++;
      $display("[TB] FAIL equal_values: ok=%b data=%0d expected 1 2", ok, rd);
    end
    finish_resp();
  endtask

  task automatic test_zero_len;
    req[3] = 1'b1;
    req_len[24 +: 8] = 8'd0;
    tick();
    req[3] = 1'b0;
    checks++;
    if (gnt !== 4'b1000 || trk_resetn !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_clear: gnt=%b trk_resetn=%b expected 1000 0", gnt, trk_resetn);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'd0 || resp_id !== 2'd3) begin
      fails++;
      $display("[TB] FAIL zero_resp: valid=%b data=%0d id=%0d expected 1 0 3", resp_valid,
               resp_data, resp_id);
    end
    finish_resp();
  endtask

  task automatic test_back_to_back;
    logic [31:0] v [8];
    logic [31:0] rd;
    int rid, lat;
    logic ok;
    v = '{32'd100, 32'd200, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    do_session(1, 2, v, rd, rid, lat, ok);
    checks++;
    if (!ok || rd !== 32'd100 || lat != 4) begin
      fails++;
      $display("[TB] FAIL b2b_first: ok=%b data=%0d lat=%0d expected 1 100 4", ok, rd, lat);
    end
    finish_resp();
    v = '{32'd1, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    do_session(1, 2, v, rd, rid, lat, ok);
    checks++;
    if (!ok || rd !== 32'd1 || rid != 1) begin
      fails++;
      $display("[TB] FAIL b2b_second: ok=%b data=%0d id=%0d expected 1 1 1", ok, rd, rid);
    end
    finish_resp();
  endtask

  task automatic test_backpressure;
    logic [31:0] v [8];
    logic [31:0] rd;
    int rid, lat;
    logic ok;
    v = '{32'd10, 32'd30, 32'd20, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    do_session(2, 3, v, rd, rid, lat, ok);
    checks++;
    if (!ok || rd !== 32'd20) begin
      fails++;
      $display("[TB] FAIL bp_result: ok=%b data=%0d expected 1 20", ok, rd);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 32'd20 || gnt !== 4'b0100) begin
        fails++;
        $display("[TB] FAIL bp_hold[%0d]: valid=%b data=%0d gnt=%b expected 1 20 0100", c,
                 resp_valid, resp_data, gnt);
      end
    end
    finish_resp();
  endtask

  task automatic test_stall;
    int n;
    logic ok;
    req[0] = 1'b1;
    req_len[0 +: 8] = 8'd5;
    tick();
    req[0] = 1'b0;
    tick();
    s_valid[0] = 1'b1;
    s_data[0 +: 32] = 32'd40;
    tick();
    s_data[0 +: 32] = 32'd50;
    tick();
    s_valid[0] = 1'b0;
    n  = 0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
      n++;
    end
`ifdef SLC_STALL_TIMEOUT_EN
    checks++;
    if (!ok || n != 8 || resp_err !== 1'b1 || resp_data !== 32'd40) begin
      fails++;
      $display("[TB] FAIL stall_timeout: ok=%b cycles=%0d err=%b data=%0d expected 1 8 1 40",
               ok, n, resp_err, resp_data);
    end
    finish_resp();
`else
    checks++;
    if (ok) begin
      fails++;
      $display("[TB] FAIL stall_wait: resp_valid rose after %0d stall cycles, expected none", n);
    end
    s_valid[0] = 1'b1;
    s_data[0 +: 32] = 32'd10;
    tick();
    s_data[0 +: 32] = 32'd60;
    tick();
    s_data[0 +: 32] = 32'd5;
    tick();
    s_valid[0] = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'd50 || resp_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL stall_resume: valid=%b data=%0d err=%b expected 1 50 0", resp_valid,
               resp_data, resp_err);
    end
    finish_resp();
`endif
  endtask

  task automatic test_reset_mid_stream;
    int bad;
    logic ok;
    req[0] = 1'b1;
    req_len[0 +: 8] = 8'd5;
    tick();
    req[0] = 1'b0;
    tick();
    s_valid[0] = 1'b1;
    s_data[0 +: 32] = 32'd77;
    tick();
    resetn  = 1'b0;
    s_valid = 4'b0;
    tick();
    checks++;
    if (gnt !== 4'b0 || s_ready !== 4'b0 || resp_valid !== 1'b0 || trk_resetn !== 1'b0 ||
        trk_din !== 32'd0 || resp_data !== 32'd0) begin
      fails++;
      $display("[TB] FAIL midreset_outputs: gnt=%b ready=%b valid=%b trk_resetn=%b din=%0d",
               gnt, s_ready, resp_valid, trk_resetn, trk_din);
    end
    resetn = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (resp_valid !== 1'b0 || gnt !== 4'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      fails++;
      $display("[TB] FAIL midreset_no_resp: %0d cycles with activity, expected 0", bad);
    end
    req = 4'b0011;
    req_len[0 +: 8] = 8'd1;
    req_len[8 +: 8] = 8'd1;
    tick();
    req = 4'b0000;
    checks++;
    if (gnt !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL midreset_ptr: gnt=%b expected 0001", gnt);
    end
    s_valid[0] = 1'b1;
    s_data[0 +: 32] = 32'd9;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    s_valid = 4'b0;
    checks++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL midreset_session: no response within 10 cycles");
    end
    finish_resp();
  endtask

  initial begin
    resetn     = 1'b0;
    req        = '0;
    req_len    = '0;
    s_valid    = '0;
    s_data     = '0;
    resp_ready = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_equal_values();
    test_zero_len();
    test_back_to_back();
    test_backpressure();
    test_stall();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/second_largest_ctrl.md
# second_largest_ctrl

Session controller that shares one `second_largest` tracker among `NUM_REQ` requesters. It round-robin arbitrates session requests, clears the tracker, and streams exactly the requested number of samples from the granted requester. It then returns the tracker's second-largest value to that requester over a response handshake. It sits between the requester ports and the single tracker instance, and drives the tracker's reset and data input directly.

## Interface
- `DATA_WIDTH`, 32, sample and result width
- `NUM_REQ`, 4, number of requesters (2..16)
- `LEN_WIDTH`, 8, width of the per-session sample count
- `TIMEOUT_CYCLES`, 64, stall limit; only used with `SLC_STALL_TIMEOUT_EN`

- `clk`  in  1  clock
- `resetn`  in  1  reset, synchronous, active-low
- `req`  in  NUM_REQ  per-requester session request, level
- `req_len`  in  NUM_REQ*LEN_WIDTH  per-requester sample count; slice i belongs to requester i
- `gnt`  out  NUM_REQ  one-hot grant, held for the whole session
- `s_valid`  in  NUM_REQ  per-requester sample valid
- `s_data`  in  NUM_REQ*DATA_WIDTH  per-requester sample data
- `s_ready`  out  NUM_REQ  per-requester sample ready
- `resp_valid`  out  1  result available
- `resp_ready`  in  1  result accepted
- `resp_data`  out  DATA_WIDTH  second-largest value of the session
- `resp_id`  out  $clog2(NUM_REQ)  index of the granted requester
- `resp_err`  out  1  session aborted by timeout
- `trk_resetn`  out  1  tracker reset, active-low
- `trk_din`  out  DATA_WIDTH  tracker sample input
- `trk_dout`  in  DATA_WIDTH  tracker second-largest output

## Operation
- States: IDLE, CLEAR, STREAM, RESP.
- IDLE:
  - If any `req` bit is set, pick the winner round-robin, latch its `req_len` into `remaining`, and latch its index.
  - Go to CLEAR.
- Round-robin priority starts at (last granted + 1) mod NUM_REQ. After reset, index 0 has highest priority.
- CLEAR:
  - `gnt` asserted, `trk_resetn`=0 for exactly one cycle.
  - Go to STREAM, or to RESP if `remaining`==0. A zero-length session therefore returns 0.
- STREAM:
  - `s_ready[g]`=1 only for the granted index; all other `s_ready` bits stay 0.
  - A sample is accepted when `s_valid[g]` && `s_ready[g]`. On that cycle `trk_din`=`s_data[g]` and `remaining` decrements.
  - On the cycle that accepts the last sample (`remaining`==1), go to RESP.
- RESP:
  - `resp_valid`=1; `resp_data`=`trk_dout`, combinational and stable because `trk_din`=0.
  - `resp_id`=granted index, `resp_err`=0.
  - When `resp_valid` && `resp_ready`, drop `gnt`, update the round-robin pointer, and go to IDLE.
- `trk_din`=0 whenever no sample is accepted. 0 never updates the tracker, because the tracker updates only on a strictly greater input.
- `trk_resetn` = `resetn` & ~(state==CLEAR).
- Requests from other requesters are ignored until IDLE. `req` deassertion by the granted requester mid-session has no effect.
- Duplicate and equal samples follow tracker semantics: a sample equal to the current max does not update the second-largest value.

## Timing
- Reset values: state=IDLE, `gnt`=0, `s_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_id`=0, `resp_err`=0, `trk_din`=0, `trk_resetn`=0.
- Reset mid-session aborts with no response.
- `req` sampled in IDLE at cycle T → CLEAR at T+1 (`gnt` rises) → STREAM at T+2 (first possible accept).
- With `s_valid` held high, N samples are accepted in cycles T+2..T+N+1 and `resp_valid` rises at T+N+2.
- Last accept at cycle L → `resp_valid` at L+1.
- Handshake at cycle H → `gnt`=0 and IDLE at H+1. The earliest next CLEAR is at H+2.
- Session overhead is 3 cycles plus response backpressure.

## Configuration
- `SLC_STALL_TIMEOUT_EN` defined:
  - A stall counter in STREAM resets on each accept and increments otherwise.
  - When it reaches `TIMEOUT_CYCLES`, go to RESP with `resp_err`=1 and `resp_data` = current `trk_dout`.
- Not defined: no counter, `resp_err` tied 0, and STREAM waits indefinitely.

## Test plan
- Requester 0, len 5, data 3,9,4,7,1, continuous valid → `resp_data`=7, `resp_id`=0, `resp_valid` 7 cycles after the `req` sample.
- Requesters 1 and 2 request together, then both request again → grants in order 1,2,1,2. The `gnt` bits are never high simultaneously.
- Len 4, data 5,5,5,2 → `resp_data`=2, because equal values do not promote to second-largest. Len 0 → `resp_data`=0 immediately after CLEAR.
- Back-to-back sessions: first session data 100,200 then second session data 1,2 → responses 100 then 1, showing the CLEAR pulse isolates sessions.
- `resp_ready` held low for 10 cycles → `resp_valid` and `resp_data` stable, `gnt` held. `resetn` low during STREAM → all outputs return to reset values next cycle.
- With `SLC_STALL_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8: accept 2 samples, then hold `s_valid` low → `resp_err`=1 on the 9th stall cycle's response.
